// File: rtl/cla_pipe_addsub.sv
// cla_pipe_addsub: five-stage carry-lookahead adder/subtractor with a global
// valid/ready stall. Bit p/g -> group P/G -> lookahead group carries -> bit
// carries -> sum/overflow.
// Optional build macro: CLA_SIGNED_SAT_EN (saturate sum on signed overflow).
// BLK must be at least 2 and divide N.

// Group propagate/generate for one BLK-bit lookahead group.
module cla_group #(
    parameter int BLK = 4
) (
    input  logic [BLK-1:0] p,
    input  logic [BLK-1:0] g,
    output logic           gp,
    output logic           gg
);
    assign gp = &p;

    // Group generate: carry out of the group assuming zero carry in.
    always_comb begin
        logic acc;
        acc = g[0];
        for (int i = 1; i < BLK; i++) acc = g[i] | (p[i] & acc);
        gg = acc;
    end
endmodule

module cla_pipe_addsub #(
    parameter int N   = 32,
    parameter int BLK = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         ovf
);
    localparam int G      = N / BLK;
    localparam int STAGES = 5;

    logic              advance;
    logic [STAGES:1]   vld_pipe;

    // S1 operands with the subtract inversion already applied
    logic [N-1:0] s1_a, s1_b;
    logic         s1_c0;
    // S2 bit propagate/generate
    logic [N-1:0] s2_p, s2_g;
    logic         s2_c0;
    // S3 group terms; only the low BLK-1 generate bits of each group are
    // still needed (for the in-group ripple), the top one lives in gg.
    logic [N-1:0]              s3_p;
    logic [G-1:0][BLK-2:0]     s3_gl;
    logic [G-1:0]              s3_gp, s3_gg;
    logic                      s3_c0;
    // S4 carry into every bit
    logic [N-1:0] s4_c, s4_p;
    logic         s4_cout;

    logic [G-1:0] grp_p, grp_g;
    logic [G:0]   gc;
    logic [N-1:0] bc;
    logic [N-1:0] sum_n;
    logic         ovf_n;

`ifdef CLA_SIGNED_SAT_EN
    // On overflow both effective operand MSBs are equal, so A's MSB alone
    // tells the direction of the saturation.
    logic s2_msb, s3_msb, s4_msb;
`endif

    // One stall signal for the whole pipe: move only if the output slot frees.
    assign advance   = ~vld_pipe[STAGES] | out_ready;
    assign in_ready  = advance;
    assign out_valid = vld_pipe[STAGES];

    // Valid shift register; bubbles travel as zeros.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)        vld_pipe <= '0;
        else if (advance) vld_pipe <= {vld_pipe[STAGES-1:1], in_valid & in_ready};
    end

    // S1: capture operands, fold subtract into inverted B and forced carry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_a  <= '0;
            s1_b  <= '0;
            s1_c0 <= 1'b0;
        end else if (advance) begin
            s1_a  <= A;
            s1_b  <= B ^ {N{sub}};
            s1_c0 <= sub | cin;
        end
    end

    // S2: per-bit propagate and generate.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_p  <= '0;
            s2_g  <= '0;
            s2_c0 <= 1'b0;
        end else if (advance) begin
            s2_p  <= s1_a ^ s1_b;
            s2_g  <= s1_a & s1_b;
            s2_c0 <= s1_c0;
        end
    end

    for (genvar j = 0; j < G; j++) begin : g_grp
        cla_group #(.BLK(BLK)) u_grp (
            .p  (s2_p[j*BLK +: BLK]),
            .g  (s2_g[j*BLK +: BLK]),
            .gp (grp_p[j]),
            .gg (grp_g[j])
        );
    end

    // S3: register group P/G alongside the bit terms still needed later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s3_p  <= '0;
            s3_gl <= '0;
            s3_gp <= '0;
            s3_gg <= '0;
            s3_c0 <= 1'b0;
        end else if (advance) begin
            s3_p  <= s2_p;
            for (int j = 0; j < G; j++) s3_gl[j] <= s2_g[j*BLK +: BLK-1];
            s3_gp <= grp_p;
            s3_gg <= grp_g;
            s3_c0 <= s2_c0;
        end
    end

    // Group carries in flat lookahead form: C[j+1] = G[j] | P[j]G[j-1] | ... | P[j..0]c0.
    always_comb begin
        logic t, pp;
        gc    = '0;
        gc[0] = s3_c0;
        for (int j = 0; j < G; j++) begin
            t  = s3_gg[j];
            pp = s3_gp[j];
            for (int k = j - 1; k >= 0; k--) begin
                t  = t | (pp & s3_gg[k]);
                pp = pp & s3_gp[k];
            end
            gc[j+1] = t | (pp & s3_c0);
        end
    end

    // Bit carries inside each group, seeded by that group's carry in.
    always_comb begin
        logic [N-1:0] cv;
        cv = '0;
        for (int j = 0; j < G; j++) begin
            cv[j*BLK] = gc[j];
            for (int i = 1; i < BLK; i++)
                cv[j*BLK+i] = s3_gl[j][i-1] | (s3_p[j*BLK+i-1] & cv[j*BLK+i-1]);
        end
        bc = cv;
    end

    // S4: register the full carry vector and the final carry out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s4_c    <= '0;
            s4_p    <= '0;
            s4_cout <= 1'b0;
        end else if (advance) begin
            s4_c    <= bc;
            s4_p    <= s3_p;
            s4_cout <= gc[G];
        end
    end

`ifdef CLA_SIGNED_SAT_EN
    // Carry the A MSB down to S5 for the saturation direction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_msb <= 1'b0;
            s3_msb <= 1'b0;
            s4_msb <= 1'b0;
        end else if (advance) begin
            s2_msb <= s1_a[N-1];
            s3_msb <= s2_msb;
            s4_msb <= s3_msb;
        end
    end

    // S5 result with signed saturation on overflow.
    always_comb begin
        ovf_n = s4_c[N-1] ^ s4_cout;
        sum_n = s4_p ^ s4_c;
        if (ovf_n) sum_n = s4_msb ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    end
`else
    // S5 result, wrapping modulo 2^N.
    always_comb begin
        ovf_n = s4_c[N-1] ^ s4_cout;
        sum_n = s4_p ^ s4_c;
    end
`endif

    // S5: output registers; hold while the consumer stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum  <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
        end else if (advance) begin
            sum  <= sum_n;
            cout <= s4_cout;
            ovf  <= ovf_n;
        end
    end
endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Directed bench for cla_pipe_addsub: 32/4 instance plus an 8/2 instance.
module tb_cla_pipe_addsub;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0, in_ready;
    logic [31:0] A = '0, B = '0;
    logic        cin = 1'b0, sub = 1'b0;
    logic        out_valid, out_ready = 1'b1;
    logic [31:0] sum;
    logic        cout, ovf;

    logic        s_in_valid = 1'b0, s_in_ready;
    logic [7:0]  s_a = '0, s_b = '0;
    logic        s_cin = 1'b0, s_sub = 1'b0;
    logic        s_out_valid;
    logic [7:0]  s_sum;
    logic        s_cout, s_ovf;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cla_pipe_addsub #(.N(32), .BLK(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
    );

    cla_pipe_addsub #(.N(8), .BLK(2)) dut_s (
        .clk(clk), .reset(reset), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .A(s_a), .B(s_b), .cin(s_cin), .sub(s_sub), .out_valid(s_out_valid),
        .out_ready(1'b1), .sum(s_sum), .cout(s_cout), .ovf(s_ovf)
    );

    // Reference: {ovf, cout, sum} for a w-bit operation, from plain wide addition.
    function automatic logic [33:0] model(input int w, input logic [31:0] a, b,
                                          input logic ci, sb);
        logic [63:0] mask, aa, bb, full, s;
        logic co, am, bm, ov;
        mask = (64'd1 << w) - 64'd1;
        aa   = {32'd0, a} & mask;
        bb   = {32'd0, b} & mask;
        if (sb) bb = (~bb) & mask;
        full = aa + bb + {63'd0, (sb | ci)};
        s    = full & mask;
        co   = full[w];
        am   = aa[w-1];
        bm   = bb[w-1];
        ov   = (am == bm) && (s[w-1] != am);
`ifdef CLA_SIGNED_SAT_EN
        if (ov) s = am ? (64'd1 << (w - 1)) : (mask >> 1);
`endif
        return {ov, co, s[31:0]};
    endfunction

    // Issue one operation with out_ready high and wait for its result.
    task automatic run_op(input logic [31:0] a, b, input logic ci, sb,
                          output logic [31:0] s, output logic co, ov, output int lat);
        @(negedge clk);
        A = a; B = b; cin = ci; sub = sb; in_valid = 1'b1; out_ready = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            lat++;
        end while (!out_valid && lat < 20);
        s = sum; co = cout; ov = ovf;
    endtask

    task automatic test_reset();
        #12;
        n_checks++;
        if ({out_valid, in_ready, sum, cout, ovf} !== {1'b0, 1'b1, 32'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: got v=%b rdy=%b sum=%h c=%b o=%b, want 0 1 0 0 0",
                     out_valid, in_ready, sum, cout, ovf);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_directed();
        logic [31:0] s;
        logic co, ov;
        int lat;
        logic [31:0] ovf_sum;
`ifdef CLA_SIGNED_SAT_EN
        ovf_sum = 32'h7FFFFFFF;
`else
        ovf_sum = 32'h80000000;
`endif
        run_op(32'hFFFFFFFF, 32'h0, 1'b1, 1'b0, s, co, ov, lat);
        n_checks++;
        if (lat != 5 || s !== 32'h0 || co !== 1'b1 || ov !== 1'b0) begin
            n_fail++;
            $display("FAIL carry_ripple: got lat=%0d sum=%h c=%b o=%b, want 5 00000000 1 0", lat, s, co, ov);
        end
        run_op(32'd5, 32'd7, 1'b0, 1'b1, s, co, ov, lat);
        n_checks++;
        if (lat != 5 || s !== 32'hFFFFFFFE || co !== 1'b0 || ov !== 1'b0) begin
            n_fail++;
            $display("FAIL sub_borrow: got lat=%0d sum=%h c=%b o=%b, want 5 fffffffe 0 0", lat, s, co, ov);
        end
        // cin must be ignored when subtracting
        run_op(32'd7, 32'd5, 1'b1, 1'b1, s, co, ov, lat);
        n_checks++;
        if (lat != 5 || s !== 32'd2 || co !== 1'b1 || ov !== 1'b0) begin
            n_fail++;
            $display("FAIL sub_noborrow: got lat=%0d sum=%h c=%b o=%b, want 5 00000002 1 0", lat, s, co, ov);
        end
        run_op(32'h7FFFFFFF, 32'd1, 1'b0, 1'b0, s, co, ov, lat);
        n_checks++;
        if (s !== ovf_sum || co !== 1'b0 || ov !== 1'b1) begin
            n_fail++;
            $display("FAIL pos_overflow: got sum=%h c=%b o=%b, want %h 0 1", s, co, ov, ovf_sum);
        end
        // negative overflow: 0x80000000 - 1
`ifdef CLA_SIGNED_SAT_EN
        ovf_sum = 32'h80000000;
`else
        ovf_sum = 32'h7FFFFFFF;
`endif
        run_op(32'h80000000, 32'd1, 1'b0, 1'b1, s, co, ov, lat);
        n_checks++;
        if (s !== ovf_sum || co !== 1'b1 || ov !== 1'b1) begin
            n_fail++;
            $display("FAIL neg_overflow: got sum=%h c=%b o=%b, want %h 1 1", s, co, ov, ovf_sum);
        end
    endtask

    task automatic test_stall();
        int wait_cyc;
        @(negedge clk);
        A = 32'h12345678; B = 32'h11111111; cin = 1'b0; sub = 1'b0;
        in_valid = 1'b1; out_ready = 1'b0;
        wait_cyc = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            wait_cyc++;
        end while (!out_valid && wait_cyc < 20);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (!out_valid || in_ready !== 1'b0 || sum !== 32'h23456789) begin
                n_fail++;
                $display("FAIL stall_hold: got v=%b rdy=%b sum=%h, want 1 0 23456789", out_valid, in_ready, sum);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_release: got out_valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] pa[20], pb[20];
        logic        pc[20], ps[20];
        logic [33:0] q[$];
        logic [33:0] exp, held;
        logic        stalled;
        int sent, got, cyc;
        for (int i = 0; i < 20; i++) begin
            pa[i] = $urandom; pb[i] = $urandom;
            pc[i] = 1'($urandom_range(0, 1)); ps[i] = 1'($urandom_range(0, 1));
        end
        sent = 0; got = 0; cyc = 0; stalled = 1'b0; held = '0;
        while (got < 20 && cyc < 500) begin
            @(negedge clk);
            cyc++;
            if (stalled) begin
                n_checks++;
                if (!out_valid || {ovf, cout, sum} !== held) begin
                    n_fail++;
                    $display("FAIL b2b_stable: got v=%b %h, want 1 %h", out_valid, {ovf, cout, sum}, held);
                end
            end
            out_ready = 1'($urandom_range(0, 1));
            if (sent < 20) begin
                A = pa[sent]; B = pb[sent]; cin = pc[sent]; sub = ps[sent]; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            n_checks++;
            if (in_ready !== (!out_valid || out_ready)) begin
                n_fail++;
                $display("FAIL b2b_in_ready: got %b with out_valid=%b out_ready=%b", in_ready, out_valid, out_ready);
            end
            if (in_valid && in_ready) begin
                q.push_back(model(32, A, B, cin, sub));
                sent++;
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_extra: unexpected result %h", {ovf, cout, sum});
                end else begin
                    exp = q.pop_front();
                    if ({ovf, cout, sum} !== exp) begin
                        n_fail++;
                        $display("FAIL b2b_result %0d: got %h, want %h", got, {ovf, cout, sum}, exp);
                    end
                end
                got++;
            end
            stalled = out_valid && !out_ready;
            held = {ovf, cout, sum};
        end
        n_checks++;
        if (got != 20 || sent != 20 || q.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_count: got sent=%0d recv=%0d pending=%0d, want 20 20 0", sent, got, q.size());
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset_midflight();
        logic [31:0] s;
        logic co, ov;
        int lat, stale;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            A = 32'(i + 1); B = 32'h100; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if (!out_valid || sum !== 32'h101) begin
            n_fail++;
            $display("FAIL pre_reset: got v=%b sum=%h, want 1 00000101", out_valid, sum);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if ({out_valid, sum, cout, ovf, in_ready} !== {1'b0, 32'd0, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL async_reset: got v=%b sum=%h c=%b o=%b rdy=%b, want 0 0 0 0 1",
                     out_valid, sum, cout, ovf, in_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        stale = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        n_checks++;
        if (stale != 0) begin
            n_fail++;
            $display("FAIL stale_after_reset: got %0d valid cycles, want 0", stale);
        end
        run_op(32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, s, co, ov, lat);
        n_checks++;
        if (lat != 5 || s !== 32'h00010000 || co !== 1'b0 || ov !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_op: got lat=%0d sum=%h c=%b o=%b, want 5 00010000 0 0", lat, s, co, ov);
        end
    endtask

    // 8-bit/2-bit build: 4096 distinct {A,B,sub,cin} points via an odd-multiplier walk.
    task automatic test_small_sweep();
        logic [33:0] q[$];
        logic [33:0] exp;
        logic [17:0] v;
        int drain;
        for (int idx = 0; idx < 4096; idx++) begin
            @(negedge clk);
            if (s_out_valid) begin
                n_checks++;
                exp = q.pop_front();
                if ({s_ovf, s_cout, s_sum} !== {exp[33:32], exp[7:0]}) begin
                    n_fail++;
                    $display("FAIL small_result: got %h, want %h", {s_ovf, s_cout, s_sum}, {exp[33:32], exp[7:0]});
                end
            end
            v = 18'(idx * 40503);
            s_a = v[17:10]; s_b = v[9:2]; s_sub = v[1]; s_cin = v[0]; s_in_valid = 1'b1;
            q.push_back(model(8, {24'd0, s_a}, {24'd0, s_b}, s_cin, s_sub));
        end
        drain = 0;
        while (q.size() != 0 && drain < 20) begin
            @(negedge clk);
            s_in_valid = 1'b0;
            drain++;
            if (s_out_valid) begin
                n_checks++;
                exp = q.pop_front();
                if ({s_ovf, s_cout, s_sum} !== {exp[33:32], exp[7:0]}) begin
                    n_fail++;
                    $display("FAIL small_result: got %h, want %h", {s_ovf, s_cout, s_sum}, {exp[33:32], exp[7:0]});
                end
            end
        end
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL small_drain: got %0d results missing, want 0", q.size());
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stall();
        test_back_to_back();
        test_reset_midflight();
        test_small_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
